jfpjc_block_dispatcher: RTL and testbench
=========================================

# jfpjc_block_dispatcher

Parametrised MCU-row ingester and block dispatcher for the jfpjc JPEG pipeline. Accepts the hm01b0 pixel bus, double-buffers eight image lines (one MCU row) in inferred EBR, then re-reads each buffered MCU row as 8x8 blocks in block-raster order. Blocks are handed round-robin to NUM_ENGINES downstream DCT engines over a tagged valid/ready stream.

## Interface
Parameters:
- IMAGE_WIDTH, 320, pixels per line; must be a multiple of 8; BLOCKS = IMAGE_WIDTH/8
- PIXEL_WIDTH, 8, bits per pixel
- NUM_ENGINES, 4, number of downstream DCT engines, 1..8; ENG_W = max(1, clog2(NUM_ENGINES))

Ports:
- clock  in  1  single clock, all logic on rising edge
- nreset  in  1  asynchronous, active-low reset
- px_data  in  PIXEL_WIDTH  pixel value
- px_valid  in  1  pixel strobe; counted only when line_valid and frame_valid are both high
- line_valid  in  1  hm01b0 line valid
- frame_valid  in  1  hm01b0 frame valid
- out_data  out  PIXEL_WIDTH  block pixel
- out_valid  out  1  out_data valid
- out_engine  out  ENG_W  destination engine of the current block
- out_first  out  1  high with pixel 0 of a block
- out_last  out  1  high with pixel 63 of a block
- out_ready  in  NUM_ENGINES  per-engine ready; a transfer is out_valid && out_ready[out_engine]
- overrun  out  1  sticky: an MCU row was dropped

## Operation
- Storage: 2 banks x 8 rows x IMAGE_WIDTH words, one synchronous read port, one write port; bank_full[1:0] flags.
- Write side: counters wcol, wrow (0..7), wbank, drop.
  - Accepted pixel with wcol < IMAGE_WIDTH: write mem[wbank][wrow][wcol] unless drop; wcol++. Pixels at wcol >= IMAGE_WIDTH are ignored.
  - First accepted pixel of an MCU row (wrow==0, wcol==0): drop <= bank_full[wbank]; if set, overrun <= 1.
  - line_valid falling edge (registered previous value) with wcol>0: wcol <= 0; wrow++. On 7->0 wrap, if !drop: bank_full[wbank] <= 1, wbank toggles. If drop: no flag set, no toggle. Lines shorter than IMAGE_WIDTH still advance wrow; unwritten columns hold stale data.
  - frame_valid low: wcol, wrow, drop <= 0; a partial MCU row is discarded; wbank is unchanged.
- Read side FSM:
  - IDLE: when bank_full[rbank], go to STREAM with blk=0, pix=0, eng=0.
  - STREAM: read address = [rbank][pix[5:3]][blk*8+pix[2:0]]. Reads issue when the output register is empty or being consumed. pix++ on each issue. On pix 63, blk++ and eng = (eng+1) mod NUM_ENGINES.
  - When the last pixel of block BLOCKS-1 transfers: clear bank_full[rbank], toggle rbank, go to IDLE.
  - eng restarts at 0 for every MCU row.
- A bank set full (write side) and the other bank cleared (read side) in the same cycle are both honoured.
- overrun is cleared only by nreset.

## Timing
- Reset values: out_valid=0, out_data=0, out_engine=0, out_first=0, out_last=0, overrun=0, bank_full=0, wbank=rbank=0, FSM=IDLE, all counters 0.
- bank_full is set on the edge that samples line_valid low after row 7. The FSM leaves IDLE on the next edge. out_valid rises on the edge after that (2 cycles after bank_full sets).
- Throughput is 1 pixel/cycle while out_ready[out_engine] is held high, with no bubbles between blocks within an MCU row. There is at least 1 idle cycle between MCU rows.
- While stalled, out_data, out_engine, out_first and out_last are held stable.
- Reset asserted mid-readout: outputs clear immediately. Buffered data is abandoned and nothing resumes after reset.

## Test plan
- IMAGE_WIDTH=16, NUM_ENGINES=2, pixel=(row*16+col)&0xFF, 8 lines, ready=2'b11 -> 128 transfers. Block 0 goes to engine 0 with data 0..7,16..23,...,112..119, first on 0, last on 119. Block 1 goes to engine 1 starting at 8 and ending at 127.
- Same stimulus with out_ready[1]=0 for 20 cycles at block 1 start -> out_valid=1, out_data=8, out_engine=1 held for 20 cycles, then the stream resumes with no lost or duplicated pixel.
- out_ready=0, feed 24 lines -> rows 0-15 buffered, rows 16-23 dropped, overrun=1. After releasing ready, exactly 256 transfers are seen, with no row 16+ data.
- Line of 20 pixels at width 16 -> pixels 16..19 ignored, the next line lands in row+1. frame_valid dropped after 3 lines -> the partial row is discarded and the next frame starts at row 0 in the same bank.
- Latency: measure the edge from bank_full set to out_valid -> exactly 2 cycles. Measure the gap between MCU rows -> at least 1 idle cycle.
- Assert nreset during block 1 -> all outputs are at reset values the same cycle. After release, feeding 8 fresh lines produces a correct MCU row from bank 0.

Source files
------------

// File: rtl/jfpjc_block_dispatcher.sv
// MCU-row ingester for the hm01b0 pixel bus: double-buffers eight lines, then replays
// each buffered row as 8x8 blocks dealt round-robin to NUM_ENGINES DCT engines.
module jfpjc_block_dispatcher #(
    parameter int IMAGE_WIDTH = 320,
    parameter int PIXEL_WIDTH = 8,
    parameter int NUM_ENGINES = 4,
    localparam int ENG_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
    input  logic                   clock,
    input  logic                   nreset,
    input  logic [PIXEL_WIDTH-1:0] px_data,
    input  logic                   px_valid,
    input  logic                   line_valid,
    input  logic                   frame_valid,
    output logic [PIXEL_WIDTH-1:0] out_data,
    output logic                   out_valid,
    output logic [ENG_W-1:0]       out_engine,
    output logic                   out_first,
    output logic                   out_last,
    input  logic [NUM_ENGINES-1:0] out_ready,
    output logic                   overrun
);

    localparam int BLOCKS = IMAGE_WIDTH / 8;
    localparam int BW     = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam int CW     = $clog2(IMAGE_WIDTH + 1);
    localparam int DEPTH  = 16 * IMAGE_WIDTH;
    localparam int AW     = $clog2(DEPTH);

    typedef struct packed {
        logic [PIXEL_WIDTH-1:0] data;
        logic [ENG_W-1:0]       engine;
        logic                   first;
        logic                   last;
    } beat_t;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    logic [PIXEL_WIDTH-1:0] mem [DEPTH];
    logic [1:0]             bank_full;

    // ---------------- write side ----------------
    logic [CW-1:0] wcol;
    logic [2:0]    wrow;
    logic          wbank, drop, lv_q;
    logic          accept, in_line, row_start, drop_now, wr_en, line_end, set_full;
    logic [AW-1:0] waddr;

    assign accept    = px_valid & line_valid & frame_valid;
    assign in_line   = wcol < CW'(IMAGE_WIDTH);
    assign row_start = (wrow == 3'd0) && (wcol == '0);
    // the drop decision for a new MCU row is made on its very first pixel
    assign drop_now  = row_start ? bank_full[wbank] : drop;
    assign wr_en     = accept & in_line & ~drop_now;
    assign line_end  = frame_valid & lv_q & ~line_valid & (wcol != '0);
    assign set_full  = line_end & (wrow == 3'd7) & ~drop;
    assign waddr     = AW'({wbank, wrow}) * AW'(IMAGE_WIDTH) + AW'(wcol);

    always_ff @(posedge clock) begin
        if (wr_en) mem[waddr] <= px_data;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wcol    <= '0;
            wrow    <= '0;
            wbank   <= 1'b0;
            drop    <= 1'b0;
            lv_q    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            lv_q <= line_valid;
            if (!frame_valid) begin
                wcol <= '0;
                wrow <= '0;
                drop <= 1'b0;
            end else begin
                if (accept && in_line) begin
                    if (row_start) begin
                        drop <= bank_full[wbank];
                        if (bank_full[wbank]) overrun <= 1'b1;
                    end
                    wcol <= wcol + 1'b1;
                end
                if (line_end) begin
                    wcol <= '0;
                    wrow <= wrow + 1'b1;
                    if (wrow == 3'd7 && !drop) wbank <= ~wbank;
                end
            end
        end
    end

    // ---------------- read side ----------------
    state_t                  state;
    logic                    rbank;
    logic [BW-1:0]           blk;
    logic [5:0]              pix;
    logic [ENG_W-1:0]        eng, eng_nxt;
    beat_t                   out_q;
    logic [(2**ENG_W)-1:0]   ready_ext;
    logic                    xfer, issue, clr_full, last_blk;
    logic [AW-1:0]           raddr;

    assign ready_ext = (2**ENG_W)'(out_ready);
    assign xfer      = out_valid & ready_ext[out_q.engine];
    // the memory read register doubles as the output register, so a read may
    // only issue into an empty slot or one that is leaving this cycle
    assign issue     = (state == STREAM) & (~out_valid | xfer);
    assign clr_full  = (state == DRAIN) & xfer;
    assign last_blk  = blk == BW'(BLOCKS - 1);
    assign eng_nxt   = (eng == ENG_W'(NUM_ENGINES - 1)) ? '0 : eng + 1'b1;
    assign raddr     = AW'({rbank, pix[5:3]}) * AW'(IMAGE_WIDTH) + AW'({blk, pix[2:0]});

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            rbank     <= 1'b0;
            blk       <= '0;
            pix       <= '0;
            eng       <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (issue)     out_valid <= 1'b1;
            else if (xfer) out_valid <= 1'b0;
            case (state)
                IDLE: if (bank_full[rbank]) begin
                    state <= STREAM;
                    blk   <= '0;
                    pix   <= '0;
                    eng   <= '0;
                end
                STREAM: if (issue) begin
                    out_q <= '{data: mem[raddr], engine: eng,
                               first: (pix == 6'd0), last: (pix == 6'd63)};
                    pix   <= pix + 1'b1;
                    if (pix == 6'd63) begin
                        eng <= eng_nxt;
                        if (last_blk) state <= DRAIN;
                        else          blk   <= blk + 1'b1;
                    end
                end
                DRAIN: if (xfer) begin
                    state <= IDLE;
                    rbank <= ~rbank;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            bank_full <= 2'b00;
        end else begin
            if (clr_full) bank_full[rbank] <= 1'b0;
            if (set_full) bank_full[wbank] <= 1'b1;
        end
    end

    assign out_data   = out_q.data;
    assign out_engine = out_q.engine;
    assign out_first  = out_q.first;
    assign out_last   = out_q.last;

endmodule

// File: tb/tb_jfpjc_block_dispatcher.sv
// Bench for jfpjc_block_dispatcher at width 16 / two engines: line-level model of
// MCU rows and bank occupancy, transfer capture, directed steps with random data.
module tb_jfpjc_block_dispatcher;

    localparam int IW  = 16;
    localparam int NE  = 2;
    localparam int BLK = IW / 8;

    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] px_data = '0;
    logic       px_valid = 1'b0, line_valid = 1'b0, frame_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [0:0] out_engine;
    logic       out_first, out_last;
    logic [1:0] out_ready = 2'b00;
    logic       overrun;

    jfpjc_block_dispatcher #(.IMAGE_WIDTH(IW), .PIXEL_WIDTH(8), .NUM_ENGINES(NE)) dut (
        .clock(clock), .nreset(nreset), .px_data(px_data), .px_valid(px_valid),
        .line_valid(line_valid), .frame_valid(frame_valid), .out_data(out_data),
        .out_valid(out_valid), .out_engine(out_engine), .out_first(out_first),
        .out_last(out_last), .out_ready(out_ready), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int          checks = 0, errors = 0;
    logic [31:0] got[$], expq[$];
    int          gotcyc[$];
    int          cyc = 0, xfers = 0, rows_pushed = 0, rows_done = 0, mrow = 0;
    bit          mdrop = 0, rand_ready = 0;
    logic [7:0]  rowbuf [0:7][0:IW-1];

    function automatic logic [31:0] beat(input logic [7:0] d, input int e, input bit f, input bit l);
        return 32'({d, 4'(e), f, l});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // one clock: capture a transfer due on the coming edge, then drive after the edge
    task automatic tick();
        @(negedge clock);
        if (nreset && out_valid && out_ready[out_engine]) begin
            got.push_back(32'({out_data, 4'(out_engine), out_first, out_last}));
            gotcyc.push_back(cyc);
            xfers++;
            if (xfers % (64 * BLK) == 0) rows_done++;
        end
        @(posedge clock);
        cyc++;
        #1;
        if (rand_ready) out_ready = 2'($urandom_range(0, 3));
    endtask

    // a complete MCU row is kept unless both banks are still occupied when it starts
    task automatic model_line(input logic [7:0] lb [0:31], input int len);
        if (mrow == 0) mdrop = (rows_pushed - rows_done) >= 2;
        for (int c = 0; c < IW && c < len; c++) rowbuf[mrow][c] = lb[c];
        mrow++;
        if (mrow == 8) begin
            mrow = 0;
            if (!mdrop) begin
                for (int b = 0; b < BLK; b++)
                    for (int p = 0; p < 64; p++)
                        expq.push_back(beat(rowbuf[p / 8][b * 8 + p % 8], b % NE, p == 0, p == 63));
                rows_pushed++;
            end
        end
    endtask

    task automatic feed_line(input int len, input bit pat, input int row, input bit stutter, input int gap);
        logic [7:0] lb [0:31];
        for (int c = 0; c < 32; c++) lb[c] = pat ? 8'((row * 16 + c) & 255) : 8'($urandom);
        model_line(lb, len);
        for (int c = 0; c < len; c++) begin
            if (stutter && $urandom_range(0, 3) == 0) begin
                line_valid = 1'b1; px_valid = 1'b0; px_data = 8'($urandom);
                tick();
            end
            line_valid = 1'b1; px_valid = 1'b1; px_data = lb[c];
            tick();
        end
        line_valid = 1'b0;
        px_valid   = stutter ? 1'($urandom) : 1'b0;
        for (int g = 0; g < gap; g++) tick();
        px_valid = 1'b0;
    endtask

    task automatic start_frame();
        frame_valid = 1'b1;
        tick(); tick();
    endtask

    task automatic end_frame();
        frame_valid = 1'b0;
        mrow = 0;
        mdrop = 0;
        tick(); tick();
    endtask

    task automatic feed_frame(input int nlines, input bit pat, input bit stutter);
        start_frame();
        for (int r = 0; r < nlines; r++) feed_line(IW, pat, r, stutter, 2);
        end_frame();
    endtask

    task automatic drain();
        int budget = 4000;
        while (got.size() < expq.size() && budget > 0) begin
            tick();
            budget--;
        end
        repeat (20) tick();
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], expq[i]);
        got.delete();
        gotcyc.delete();
        expq.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // reset state
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_engine", out_engine, 0);
        chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0);
        chk("rst_overrun", overrun, 0);
        nreset = 1'b1;
        tick();

        // basic MCU row with the ramp pattern, plus bank_full -> out_valid latency
        out_ready = 2'b11;
        start_frame();
        for (int r = 0; r < 7; r++) feed_line(IW, 1, r, 0, 2);
        feed_line(IW, 1, 7, 0, 0);
        tick();
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("latency", n, 2);
        end_frame();
        drain();
        chk("b0_first", got[0], beat(8'd0, 0, 1, 0));
        chk("b0_last", got[63], beat(8'd119, 0, 0, 1));
        chk("b1_first", got[64], beat(8'd8, 1, 1, 0));
        chk("b1_last", got[127], beat(8'd127, 1, 0, 1));
        compare_all("ramp");

        // engine 1 stalled at the start of block 1
        out_ready = 2'b01;
        feed_frame(8, 1, 0);
        n = 0;
        while (!(out_valid && out_engine == 1'b1) && n < 500) begin
            tick();
            n++;
        end
        chk("stall_reach", 32'(out_valid && out_engine == 1'b1), 1);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("stall_hold%0d", k), {out_valid, out_data, out_engine, out_first},
                {1'b1, 8'd8, 1'b1, 1'b1});
            tick();
        end
        out_ready = 2'b11;
        drain();
        compare_all("stall");

        // overrun: 24 lines with no readout, third MCU row is dropped
        out_ready = 2'b00;
        feed_frame(24, 0, 0);
        chk("overrun_set", overrun, 1);
        chk("no_xfer_blocked", got.size(), 0);
        out_ready = 2'b11;
        drain();
        chk("row_gap", 32'((gotcyc.size() > 128) && (gotcyc[128] - gotcyc[127] >= 2)), 1);
        compare_all("overrun");

        // overlong line and an aborted partial frame
        start_frame();
        feed_line(20, 0, 0, 0, 2);
        feed_line(IW, 0, 1, 0, 2);
        feed_line(IW, 0, 2, 0, 2);
        end_frame();
        start_frame();
        for (int r = 0; r < 8; r++) feed_line((r == 2) ? 20 : IW, 0, r, 1, 2);
        end_frame();
        drain();
        chk("overrun_sticky", overrun, 1);
        compare_all("partial");

        // two back-to-back rows with random per-cycle ready
        rand_ready = 1;
        feed_frame(16, 0, 1);
        drain();
        rand_ready = 0;
        out_ready = 2'b11;
        compare_all("randready");

        // reset during block 1 of a readout
        feed_frame(8, 0, 0);
        n = 0;
        while (!(out_valid && out_engine == 1'b1) && n < 500) begin
            tick();
            n++;
        end
        chk("rst_reach", 32'(out_valid && out_engine == 1'b1), 1);
        nreset = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_engine", out_engine, 0);
        chk("mid_rst_first", out_first, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_overrun", overrun, 0);
        got.delete();
        gotcyc.delete();
        expq.delete();
        xfers = 0;
        rows_pushed = 0;
        rows_done = 0;
        mrow = 0;
        mdrop = 0;
        repeat (3) tick();
        nreset = 1'b1;
        repeat (30) tick();
        chk("no_resume", got.size(), 0);
        chk("no_resume_valid", out_valid, 0);
        feed_frame(8, 0, 0);
        drain();
        compare_all("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
